// File: rtl/pkt_dispatcher_if.sv
// Packet stream interface: one ingress word stream and two valid/ready egress channels.
// The dispatcher takes the slave view; the producer/consumer side takes the master view.
interface pkt_dispatcher_if;
  logic         data_in_valid;
  logic [133:0] data_in;
  logic         cpu_out_valid;
  logic [133:0] cpu_out;
  logic         cpu_out_ready;
  logic         fwd_out_valid;
  logic [133:0] fwd_out;
  logic         fwd_out_ready;

  modport slave (
    input  data_in_valid, data_in, cpu_out_ready, fwd_out_ready,
    output cpu_out_valid, cpu_out, fwd_out_valid, fwd_out
  );

  modport master (
    output data_in_valid, data_in, cpu_out_ready, fwd_out_ready,
    input  cpu_out_valid, cpu_out, fwd_out_valid, fwd_out
  );
endinterface

// File: rtl/pkt_dispatcher.sv
// Store-and-forward packet dispatcher: buffers whole packets, then steers each to the
// CPU or forward channel by the head tag; malformed/overflowing packets are dropped and counted.
module pkt_dispatcher #(
  parameter int DATA_AW = 8,
  parameter int INFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pkt_dispatcher_if.slave  bus,
  output logic [31:0]      cpu_pkt_cnt,
  output logic [31:0]      fwd_pkt_cnt,
  output logic [31:0]      drop_pkt_cnt
);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;
  localparam logic [DATA_AW-1:0] DATA_ONE = {{(DATA_AW-1){1'b0}}, 1'b1};
  localparam logic [INFO_AW:0]   INFO_ONE = {{INFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, SEND} rd_state_e;

  logic [133:0] data_mem [2**DATA_AW];
  logic         info_mem [2**INFO_AW];

  logic [DATA_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_AW-1:0] commit_ptr_q, commit_ptr_d;
  logic [DATA_AW-1:0] rd_ptr_q;
  logic               in_pkt_q, in_pkt_d;
  logic               drop_q, drop_d;
  logic               dest_q, dest_d;
  logic [INFO_AW:0]   info_wptr_q, info_wptr_d;
  logic [INFO_AW:0]   info_rptr_q;
  logic [31:0]        drop_cnt_q;
  logic [31:0]        cpu_cnt_q;
  logic [31:0]        fwd_cnt_q;

  logic [1:0]         pkt_type;
  logic               head_is_cpu;
  logic [INFO_AW:0]   info_count;
  logic               info_full;
  logic               info_empty;
  logic               wr_en;
  logic [DATA_AW-1:0] wr_addr;
  logic [DATA_AW-1:0] base;
  logic               push;
  logic               push_dest;
  logic [1:0]         drop_inc;

  rd_state_e          state_q;
  logic               rd_dest_q;
  logic [133:0]       rd_data_q;
  logic [133:0]       out_data_q;
  logic               cpu_valid_q;
  logic               fwd_valid_q;
  logic               rd_en;
  logic [DATA_AW-1:0] rd_addr;
  logic               xfer;

  assign pkt_type    = bus.data_in[133:132];
  assign head_is_cpu = (bus.data_in[1:0] == 2'b11);
  assign info_count  = info_wptr_q - info_rptr_q;
  assign info_full   = info_count[INFO_AW];
  assign info_empty  = (info_count == '0);

  // A head arriving mid-packet rolls back to commit_ptr first, so one word can cost two drops.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    in_pkt_d     = in_pkt_q;
    drop_d       = drop_q;
    dest_d       = dest_q;
    info_wptr_d  = info_wptr_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;
    push         = 1'b0;
    push_dest    = dest_q;
    drop_inc     = 2'd0;
    base         = wr_ptr_q;
    if (bus.data_in_valid) begin
      case (pkt_type)
        T_HEAD, T_SINGLE: begin
          if (in_pkt_q) begin
            base     = commit_ptr_q;
            drop_inc = drop_inc + 2'd1;
          end
          wr_ptr_d = base;
          in_pkt_d = 1'b0;
          drop_d   = 1'b0;
          if (info_full || (base + DATA_ONE == rd_ptr_q)) begin
            drop_inc = drop_inc + 2'd1;
            drop_d   = (pkt_type == T_HEAD);
          end else begin
            wr_en    = 1'b1;
            wr_addr  = base;
            wr_ptr_d = base + DATA_ONE;
            if (pkt_type == T_HEAD) begin
              in_pkt_d = 1'b1;
              dest_d   = head_is_cpu;
            end else begin
              commit_ptr_d = base + DATA_ONE;
              push         = 1'b1;
              push_dest    = head_is_cpu;
            end
          end
        end
        default: begin
          if (in_pkt_q) begin
            if (wr_ptr_q + DATA_ONE == rd_ptr_q) begin
              wr_ptr_d = commit_ptr_q;
              in_pkt_d = 1'b0;
              drop_d   = (pkt_type == T_BODY);
              drop_inc = 2'd1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + DATA_ONE;
              if (pkt_type == T_TAIL) begin
                commit_ptr_d = wr_ptr_q + DATA_ONE;
                push         = 1'b1;
                in_pkt_d     = 1'b0;
              end
            end
          end else if (drop_q && (pkt_type == T_TAIL)) begin
            drop_d = 1'b0;
          end
        end
      endcase
    end
    if (push) begin
      info_wptr_d = info_wptr_q + INFO_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      in_pkt_q     <= 1'b0;
      drop_q       <= 1'b0;
      dest_q       <= 1'b0;
      info_wptr_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      in_pkt_q     <= in_pkt_d;
      drop_q       <= drop_d;
      dest_q       <= dest_d;
      info_wptr_q  <= info_wptr_d;
      drop_cnt_q   <= drop_cnt_q + {30'd0, drop_inc};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_addr] <= bus.data_in;
    end
    if (push) begin
      info_mem[info_wptr_q[INFO_AW-1:0]] <= push_dest;
    end
    if (rd_en) begin
      rd_data_q <= data_mem[rd_addr];
    end
  end

  // In SEND, rd_data_q always holds the word at rd_ptr, ready to replace the word just taken.
  assign xfer = (cpu_valid_q && bus.cpu_out_ready) || (fwd_valid_q && bus.fwd_out_ready);

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_ptr_q + DATA_ONE;
    case (state_q)
      IDLE: begin
        rd_en   = !info_empty;
        rd_addr = rd_ptr_q;
      end
      LOAD:    rd_en = 1'b1;
      SEND:    rd_en = xfer && !out_data_q[133];
      default: rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      info_rptr_q <= '0;
      rd_dest_q   <= 1'b0;
      out_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      fwd_valid_q <= 1'b0;
      cpu_cnt_q   <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!info_empty) begin
            info_rptr_q <= info_rptr_q + INFO_ONE;
            rd_dest_q   <= info_mem[info_rptr_q[INFO_AW-1:0]];
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          out_data_q  <= rd_data_q;
          cpu_valid_q <= rd_dest_q;
          fwd_valid_q <= !rd_dest_q;
          rd_ptr_q    <= rd_ptr_q + DATA_ONE;
          state_q     <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (out_data_q[133]) begin
              cpu_valid_q <= 1'b0;
              fwd_valid_q <= 1'b0;
              if (cpu_valid_q) begin
                cpu_cnt_q <= cpu_cnt_q + 32'd1;
              end else begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
              end
              state_q <= IDLE;
            end else begin
              out_data_q <= rd_data_q;
              rd_ptr_q   <= rd_ptr_q + DATA_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_out_valid = cpu_valid_q;
  assign bus.cpu_out       = out_data_q;
  assign bus.fwd_out_valid = fwd_valid_q;
  assign bus.fwd_out       = out_data_q;
  assign cpu_pkt_cnt       = cpu_cnt_q;
  assign fwd_pkt_cnt       = fwd_cnt_q;
  assign drop_pkt_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Bench for pkt_dispatcher: directed scenarios plus randomized traffic, scored against a
// packet-level model (expected word queue and per-channel/drop packet tallies).
module tb_pkt_dispatcher;

  localparam int DATA_AW   = 4;
  localparam int INFO_AW   = 4;
  localparam int BUF_WORDS = (2**DATA_AW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_dispatcher_if bus();
  logic [31:0] cpu_pkt_cnt;
  logic [31:0] fwd_pkt_cnt;
  logic [31:0] drop_pkt_cnt;

  pkt_dispatcher #(.DATA_AW(DATA_AW), .INFO_AW(INFO_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cpu_pkt_cnt  (cpu_pkt_cnt),
    .fwd_pkt_cnt  (fwd_pkt_cnt),
    .drop_pkt_cnt (drop_pkt_cnt)
  );

  int           testCount = 0;
  int           failCount = 0;
  logic [133:0] expWord[$];
  bit           expDest[$];
  int           expCpu, expFwd, expDrop;
  bit           monitorOn;
  int           readyMode;
  int           readyPhase = 0;
  bit           heldValid;
  logic [1:0]   heldCh;
  logic [133:0] heldData;
  logic [133:0] monData;

  task automatic checkOutput(input string tag, input logic [133:0] observed, input logic [133:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [133:0] mkWord(input logic [1:0] kind, input logic [31:0] low);
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    return {kind, d[3:0], c, b, a, low};
  endfunction

  function automatic logic [31:0] mkTag(input bit toCpu);
    logic [31:0] r;
    r = $urandom;
    if (toCpu) r[1:0] = 2'b11;
    else       r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Output-side ready patterns: 0 always ready, 1 random, 2 repeating 1,0,0.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      1: begin
        bus.cpu_out_ready = ($urandom_range(0, 3) != 0);
        bus.fwd_out_ready = ($urandom_range(0, 3) != 0);
      end
      2: begin
        bus.cpu_out_ready = (readyPhase == 0);
        bus.fwd_out_ready = (readyPhase == 0);
        readyPhase = (readyPhase + 1) % 3;
      end
      default: begin
        bus.cpu_out_ready = 1'b1;
        bus.fwd_out_ready = 1'b1;
      end
    endcase
  end

  // Scoreboard: every transfer must match the oldest expected word and its channel.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (bus.cpu_out_valid || bus.fwd_out_valid) begin
        monData = bus.cpu_out_valid ? bus.cpu_out : bus.fwd_out;
        if (heldValid) checkOutput("stall_hold", monData, heldData);
        if (expWord.size() == 0) begin
          checkOutput("spurious_valid", {132'd0, bus.cpu_out_valid, bus.fwd_out_valid}, 134'd0);
          heldValid = 1'b0;
        end else begin
          checkOutput("channel", {132'd0, bus.cpu_out_valid, bus.fwd_out_valid},
                      expDest[0] ? 134'd2 : 134'd1);
          if ((bus.cpu_out_valid && bus.cpu_out_ready) || (bus.fwd_out_valid && bus.fwd_out_ready)) begin
            checkOutput("word", monData, expWord[0]);
            void'(expWord.pop_front());
            void'(expDest.pop_front());
            heldValid = 1'b0;
          end else begin
            heldValid = 1'b1;
            heldCh    = {bus.cpu_out_valid, bus.fwd_out_valid};
            heldData  = monData;
          end
        end
      end else begin
        if (heldValid) checkOutput("stall_valid_drop", {132'd0, bus.cpu_out_valid, bus.fwd_out_valid}, {132'd0, heldCh});
        heldValid = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [133:0] w);
    bus.data_in       = w;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendPacket(input int len, input logic [31:0] tag, input bit accepted, input int gapMax);
    logic [133:0] words[$];
    logic [1:0]   kind;
    for (int i = 0; i < len; i++) begin
      if (len == 1)          kind = 2'b11;
      else if (i == 0)       kind = 2'b01;
      else if (i == len - 1) kind = 2'b10;
      else                   kind = 2'b00;
      words.push_back(mkWord(kind, (i == 0) ? tag : $urandom));
    end
    for (int i = 0; i < len; i++) begin
      if (gapMax > 0 && i > 0) idleCycles($urandom_range(0, gapMax));
      applyStimulus(words[i]);
    end
    if (accepted) begin
      for (int i = 0; i < len; i++) begin
        expWord.push_back(words[i]);
        expDest.push_back(tag[1:0] == 2'b11);
      end
      if (tag[1:0] == 2'b11) expCpu++;
      else                   expFwd++;
    end
  endtask

  task automatic sendFragment(input int bodies);
    applyStimulus(mkWord(2'b01, mkTag($urandom_range(0, 1) == 1)));
    for (int i = 0; i < bodies; i++) applyStimulus(mkWord(2'b00, $urandom));
  endtask

  task automatic waitSpace(input int need);
    int n = 0;
    while (expWord.size() + need > BUF_WORDS && n < 3000) begin
      idleCycles(1);
      n++;
    end
    if (expWord.size() + need > BUF_WORDS)
      checkOutput("space_timeout", 134'(expWord.size()), 134'(BUF_WORDS - need));
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expWord.size() != 0 && n < 3000) begin
      idleCycles(1);
      n++;
    end
    if (expWord.size() != 0) checkOutput("drain_timeout", 134'(expWord.size()), 134'd0);
    idleCycles(3);
  endtask

  task automatic waitLatency(input bit onCpu, output int lat);
    lat = 0;
    while (!(onCpu ? bus.cpu_out_valid : bus.fwd_out_valid) && lat < 20) begin
      idleCycles(1);
      lat++;
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached with %0d words outstanding", expWord.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int len, frag, kind;
    rst_n             = 1'b0;
    monitorOn         = 1'b0;
    heldValid         = 1'b0;
    readyMode         = 0;
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    expCpu = 0; expFwd = 0; expDrop = 0;
    idleCycles(3);
    checkOutput("reset_cpu_valid", bus.cpu_out_valid, 0);
    checkOutput("reset_fwd_valid", bus.fwd_out_valid, 0);
    checkOutput("reset_cpu_cnt", cpu_pkt_cnt, 0);
    checkOutput("reset_fwd_cnt", fwd_pkt_cnt, 0);
    checkOutput("reset_drop_cnt", drop_pkt_cnt, 0);
    rst_n     = 1'b1;
    monitorOn = 1'b1;
    idleCycles(2);

    // 4-word CPU packet: two-cycle latency, then a bubble-free burst
    sendPacket(4, 32'd3, 1'b1, 0);
    waitLatency(1'b1, lat);
    checkOutput("cpu_latency", lat, 2);
    for (int i = 0; i < 3; i++) begin
      idleCycles(1);
      checkOutput("cpu_burst_valid", bus.cpu_out_valid, 1);
    end
    idleCycles(1);
    checkOutput("cpu_valid_after_tail", bus.cpu_out_valid, 0);
    checkOutput("cpu_cnt_first", cpu_pkt_cnt, expCpu);
    checkOutput("fwd_cnt_first", fwd_pkt_cnt, expFwd);

    // Same shape with tag 1 goes to the forward channel
    sendPacket(4, 32'd1, 1'b1, 0);
    waitLatency(1'b0, lat);
    checkOutput("fwd_latency", lat, 2);
    waitDrain();
    checkOutput("fwd_cnt_tag1", fwd_pkt_cnt, expFwd);
    checkOutput("cpu_cnt_tag1", cpu_pkt_cnt, expCpu);

    // Stalling forward channel
    readyMode = 2;
    sendPacket(6, mkTag(1'b0), 1'b1, 0);
    waitDrain();
    readyMode = 0;
    checkOutput("fwd_cnt_stall", fwd_pkt_cnt, expFwd);

    // Fragment cut off by a new head
    sendFragment(1);
    expDrop++;
    sendPacket(3, mkTag(1'b1), 1'b1, 0);
    waitDrain();
    checkOutput("drop_cnt_fragment", drop_pkt_cnt, expDrop);
    checkOutput("cpu_cnt_fragment", cpu_pkt_cnt, expCpu);

    // Overflow: 20 and 16 words cannot fit, 15 just fits
    sendPacket(20, mkTag(1'b0), 1'b0, 0);
    expDrop++;
    sendPacket(4, mkTag(1'b0), 1'b1, 0);
    waitDrain();
    checkOutput("drop_cnt_overflow20", drop_pkt_cnt, expDrop);
    sendPacket(16, mkTag(1'b1), 1'b0, 0);
    expDrop++;
    sendPacket(15, mkTag(1'b1), 1'b1, 0);
    waitDrain();
    checkOutput("drop_cnt_overflow16", drop_pkt_cnt, expDrop);
    checkOutput("cpu_cnt_full15", cpu_pkt_cnt, expCpu);
    checkOutput("fwd_cnt_overflow", fwd_pkt_cnt, expFwd);

    // Reset in the middle of an output packet
    readyMode = 2;
    sendPacket(8, mkTag(1'b1), 1'b1, 0);
    waitLatency(1'b1, lat);
    checkOutput("presend_latency", lat, 2);
    idleCycles(2);
    monitorOn = 1'b0;
    rst_n     = 1'b0;
    idleCycles(1);
    checkOutput("midreset_cpu_valid", bus.cpu_out_valid, 0);
    checkOutput("midreset_fwd_valid", bus.fwd_out_valid, 0);
    checkOutput("midreset_cpu_cnt", cpu_pkt_cnt, 0);
    checkOutput("midreset_fwd_cnt", fwd_pkt_cnt, 0);
    checkOutput("midreset_drop_cnt", drop_pkt_cnt, 0);
    rst_n = 1'b1;
    expWord.delete();
    expDest.delete();
    expCpu = 0; expFwd = 0; expDrop = 0;
    heldValid = 1'b0;
    monitorOn = 1'b1;
    readyMode = 0;
    sendPacket(2, mkTag(1'b0), 1'b1, 0);
    waitDrain();
    checkOutput("postreset_fwd_cnt", fwd_pkt_cnt, expFwd);

    // Randomized traffic with gaps, fragments and stray words
    readyMode = 1;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      frag = (kind == 8) ? $urandom_range(1, 3) : 0;
      waitSpace(len + frag);
      if (kind == 8) begin
        sendFragment(frag - 1);
        expDrop++;
      end
      if (kind == 9) applyStimulus(mkWord(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, $urandom));
      sendPacket(len, mkTag($urandom_range(0, 1) == 1), 1'b1, 2);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 4));
    end
    waitDrain();
    checkOutput("final_cpu_cnt", cpu_pkt_cnt, expCpu);
    checkOutput("final_fwd_cnt", fwd_pkt_cnt, expFwd);
    checkOutput("final_drop_cnt", drop_pkt_cnt, expDrop);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pkt_dispatcher.md
Name: pkt_dispatcher

Overview:
- Sits directly downstream of the TCP parser stage.
- Consumes the parser's 134-bit packet stream, which has no backpressure, and stores each packet whole in a buffer.
- A packet is released only after its tail has been accepted. It then goes to one of two output channels, CPU or forward, chosen by the metadata tag in its head word.
- Malformed and overflowing packets are dropped atomically and counted.

Parameters:
DATA_AW, 8, log2 depth of the packet data buffer (256 words of 134 bits)
INFO_AW, 4, log2 depth of the packet info FIFO (16 packets)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_in_valid  in  1  input word strobe; no backpressure
data_in  in  134  [133:132]: 01 head, 00 body, 10 tail, 11 single-word packet; head word [31:0] is the metadata tag
cpu_out_valid  out  1  CPU channel word valid
cpu_out  out  134  CPU channel word
cpu_out_ready  in  1  CPU channel accepts word
fwd_out_valid  out  1  forward channel word valid
fwd_out  out  134  forward channel word
fwd_out_ready  in  1  forward channel accepts word
cpu_pkt_cnt  out  32  packets fully sent on CPU channel
fwd_pkt_cnt  out  32  packets fully sent on forward channel
drop_pkt_cnt  out  32  packets dropped

Behaviour:
- Reset: rst_n is sampled on the rising clk edge (synchronous, active-low).
  - All outputs go to 0, all pointers to 0, FSM to IDLE, counters to 0.
  - Reset aborts any in-flight input or output packet without counting it.
- Write side: one word per cycle. The data buffer has three pointers: wr_ptr, commit_ptr and rd_ptr. Full means wr_ptr+1 == rd_ptr, modulo wrap.
  - Head:
    - If the info FIFO is full, set a drop flag: discard words up to and including the tail, and increment drop_pkt_cnt once.
    - Otherwise latch dest = (data_in[1:0] == 2'b11) ? CPU : FWD, write the word, and enter IN_PKT.
  - Body in IN_PKT: write the word.
  - Tail in IN_PKT: write the word, set commit_ptr to the new wr_ptr, and push {dest} into the info FIFO in the same cycle.
  - Single-word packet (11): head and tail handling in one cycle. The info FIFO full check still applies.
  - Head while IN_PKT: roll wr_ptr back to commit_ptr, increment drop_pkt_cnt, then process the new head normally in the same cycle.
  - Body or tail while not IN_PKT (no preceding head): discard the word; no count.
  - Buffer full on a write in IN_PKT: roll wr_ptr back to commit_ptr, increment drop_pkt_cnt, and discard the rest of the packet through its tail.
  - data_in_valid=0 mid-packet is legal: gaps are tolerated and state is held.
- Read side FSM:
  - IDLE: if the info FIFO is not empty, pop it, latch dest, issue a buffer read at rd_ptr, go to LOAD.
  - LOAD: capture the word into the output register of the dest channel, assert its valid, advance rd_ptr, go to SEND.
  - SEND: on valid && ready, transfer the word.
    - If it was the tail (type 10 or 11), drop valid, increment that channel's packet counter, go to IDLE.
    - Otherwise present the next word, which must be prefetched so that back-to-back words follow with no bubble while ready stays high.
- Output rules:
  - Valid and data are held stable while valid && !ready.
  - Only the dest channel is ever valid; the other channel's valid stays 0.
  - Data is unmodified, metadata included.
  - rd_ptr never passes commit_ptr.
- Latency: with an empty buffer and the channel ready, the head word is valid on the output 2 cycles after the tail cycle at input. Packets leave in arrival order, one at a time.
- Simultaneous write-commit and read: legal in the same cycle.
- Counters wrap at 2^32.

Test Plan:
- 4-word packet, head[31:0]=3, cpu_out_ready=1 -> cpu_out carries the 4 identical words on consecutive cycles, the first 2 cycles after the tail; fwd_out_valid stays 0; cpu_pkt_cnt=1.
- Same packet with tag=1 -> emitted on fwd_out; fwd_pkt_cnt=1; cpu_pkt_cnt=0.
- fwd_out_ready toggled 1,0,0,1,... during a 6-word packet -> data held stable while stalled; all 6 words in order; no duplicates or losses.
- Head, body, then a new head and a 3-word packet -> first fragment never emitted; drop_pkt_cnt=1; the 3-word packet emitted intact.
- DATA_AW=4 and a 20-word packet, then a 4-word packet -> first dropped (drop_pkt_cnt=1); second emitted; buffer empty afterwards.
- rst_n=0 for one cycle mid-SEND -> next cycle all valids 0 and counters 0; a subsequent packet is processed normally.
